// File: rtl/alu_port_arbiter_if.sv
// Bundle of the two bus-master ports and the shared ALU slave port.
// The arbiter uses the slave modport. The bus side (masters plus ALU) uses the master modport.
interface alu_port_arbiter_if;
  logic        m0_req, m0_wr, m0_gnt, m0_rvalid, m0_irq;
  logic [15:0] m0_addr;
  logic [31:0] m0_din, m0_dout;
  logic        m1_req, m1_wr, m1_gnt, m1_rvalid, m1_irq;
  logic [15:0] m1_addr;
  logic [31:0] m1_din, m1_dout;
  logic        s_sel, s_wr, s_interrupt;
  logic [15:0] s_addr;
  logic [31:0] s_din, s_dout;

  modport slave (
    input  m0_req, m0_wr, m0_addr, m0_din, m1_req, m1_wr, m1_addr, m1_din,
           s_dout, s_interrupt,
    output m0_gnt, m0_dout, m0_rvalid, m0_irq, m1_gnt, m1_dout, m1_rvalid, m1_irq,
           s_sel, s_wr, s_addr, s_din
  );

  modport master (
    output m0_req, m0_wr, m0_addr, m0_din, m1_req, m1_wr, m1_addr, m1_din,
           s_dout, s_interrupt,
    input  m0_gnt, m0_dout, m0_rvalid, m0_irq, m1_gnt, m1_dout, m1_rvalid, m1_irq,
           s_sel, s_wr, s_addr, s_din
  );
endinterface

// File: rtl/alu_port_arbiter.sv
// Round-robin arbiter sharing one ALU slave port between CPU (m0) and DMAC (m1).
// It enforces burst capping, steers read returns back to the issuer, and routes the interrupt to the last writer.
module alu_port_arbiter #(
  parameter int MAX_BURST = 8,
  parameter int RD_LAT    = 1
) (
  input logic             clk,
  input logic             reset_n,
  alu_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  localparam logic [8:0] MAX9 = 9'(MAX_BURST);

  state_t          state;
  logic [1:0]      req, gnt, xfer;
  logic            any_xfer, owner, own_req, oth_req, idle_pick, swap, rd_push;
  logic            last_grant, irq_own;
  logic [7:0]      burst_cnt;
  logic [8:0]      cnt_inc;
  logic [RD_LAT:1] vld_pipe, own_pipe;

  assign req      = {bus.m1_req, bus.m0_req};
  assign xfer     = req & gnt;
  assign any_xfer = |xfer;
  assign owner    = gnt[1];
  assign own_req  = owner ? req[1] : req[0];
  assign oth_req  = owner ? req[0] : req[1];
  assign idle_pick = (&req) ? ~last_grant : req[1];
  assign cnt_inc  = {1'b0, burst_cnt} + 9'd1;
  // Hand over on release, or when the cap is reached and the other master is waiting.
  assign swap     = own_req ? (oth_req && cnt_inc >= MAX9) : oth_req;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      gnt        <= 2'b00;
      last_grant <= 1'b1;
      burst_cnt  <= 8'd0;
    end else begin
      case (state)
        IDLE: if (|req) begin
          state      <= idle_pick ? OWN1 : OWN0;
          gnt        <= idle_pick ? 2'b10 : 2'b01;
          last_grant <= idle_pick;
          burst_cnt  <= 8'd0;
        end
        OWN0, OWN1: begin
          if (swap) begin
            state      <= owner ? OWN0 : OWN1;
            gnt        <= owner ? 2'b01 : 2'b10;
            last_grant <= ~owner;
            burst_cnt  <= 8'd0;
          end else if (!own_req) begin
            state     <= IDLE;
            gnt       <= 2'b00;
            burst_cnt <= 8'd0;
          end else begin
            burst_cnt <= (cnt_inc >= MAX9) ? MAX9[7:0] : cnt_inc[7:0];
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= 2'b00;
        end
      endcase
    end
  end

  assign bus.m0_gnt = gnt[0];
  assign bus.m1_gnt = gnt[1];
  assign bus.s_sel  = any_xfer;
  assign bus.s_wr   = any_xfer & (owner ? bus.m1_wr : bus.m0_wr);
  assign bus.s_addr = !any_xfer ? 16'd0 : owner ? bus.m1_addr : bus.m0_addr;
  assign bus.s_din  = !any_xfer ? 32'd0 : owner ? bus.m1_din : bus.m0_din;
  assign rd_push    = any_xfer & ~bus.s_wr;

  // Read tags ride a fixed-latency pipe, independent of later grant changes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_pipe <= '0;
      own_pipe <= '0;
      irq_own  <= 1'b0;
    end else begin
      vld_pipe[1] <= rd_push;
      own_pipe[1] <= owner;
      for (int i = 2; i <= RD_LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        own_pipe[i] <= own_pipe[i-1];
      end
      if (any_xfer && bus.s_wr) irq_own <= owner;
    end
  end

  assign bus.m0_rvalid = vld_pipe[RD_LAT] & ~own_pipe[RD_LAT];
  assign bus.m1_rvalid = vld_pipe[RD_LAT] &  own_pipe[RD_LAT];
  assign bus.m0_dout   = bus.s_dout;
  assign bus.m1_dout   = bus.s_dout;
  assign bus.m0_irq    = reset_n & bus.s_interrupt & ~irq_own;
  assign bus.m1_irq    = reset_n & bus.s_interrupt &  irq_own;
endmodule

// File: tb/tb_alu_port_arbiter.sv
// Randomized bench for alu_port_arbiter against a tenure/queue-based reference model.
module tb_alu_port_arbiter;
  localparam int MAX_BURST = 4;
  localparam int RD_LAT    = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  alu_port_arbiter_if bus ();
  alu_port_arbiter #(.MAX_BURST(MAX_BURST), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Bench-side master state
  logic        pend [2];
  logic        wr   [2];
  logic [15:0] addr [2];
  logic [31:0] din  [2];
  logic [31:0] dout_v;
  logic        intr_v;

  // Reference model: current owner (-1 none), last granted, transfers this tenure,
  // last writer and outstanding reads with their due cycle.
  typedef struct { int due; int m; } rd_t;
  rd_t rdq[$];
  int  own, last_g, tcnt, irq_o, cyc;

  task automatic model_reset();
    own = -1; last_g = 1; tcnt = 0; irq_o = 0; rdq.delete();
    pend[0] = 1'b0; pend[1] = 1'b0;
  endtask

  task automatic drive();
    bus.m0_req = pend[0]; bus.m0_wr = wr[0]; bus.m0_addr = addr[0]; bus.m0_din = din[0];
    bus.m1_req = pend[1]; bus.m1_wr = wr[1]; bus.m1_addr = addr[1]; bus.m1_din = din[1];
    bus.s_dout = dout_v; bus.s_interrupt = intr_v;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_gnt0"}, {31'd0, bus.m0_gnt}, 32'd0);
    chk({tag, "_gnt1"}, {31'd0, bus.m1_gnt}, 32'd0);
    chk({tag, "_sel"},  {31'd0, bus.s_sel}, 32'd0);
    chk({tag, "_rv0"},  {31'd0, bus.m0_rvalid}, 32'd0);
    chk({tag, "_rv1"},  {31'd0, bus.m1_rvalid}, 32'd0);
    chk({tag, "_irq0"}, {31'd0, bus.m0_irq}, 32'd0);
    chk({tag, "_irq1"}, {31'd0, bus.m1_irq}, 32'd0);
  endtask

  // Reset asserted mid-cycle, away from the edge: everything must drop at once.
  task automatic do_reset();
    @(posedge clk); #2;
    reset_n = 1'b0;
    intr_v = 1'b1;
    bus.s_interrupt = 1'b1;
    #1 chk_quiet("rst_now");
    model_reset();
    drive();
    @(negedge clk); #1 chk_quiet("rst_hold");
    @(posedge clk); #2;
    reset_n = 1'b1;
  endtask

  task automatic run_cycles(input int n, input int p0, input int p1);
    int xm, nown, o;
    logic rv [2];
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
        if (!pend[m] && $urandom_range(99) < (m == 0 ? p0 : p1)) begin
          pend[m] = 1'b1;
          wr[m]   = 1'($urandom_range(1));
          addr[m] = 16'($urandom);
          din[m]  = $urandom;
        end
      end
      dout_v = $urandom;
      intr_v = ($urandom_range(3) == 0);
      drive();
      #1;
      xm = (own >= 0 && pend[own]) ? own : -1;
      rv[0] = 1'b0; rv[1] = 1'b0;
      foreach (rdq[i]) if (rdq[i].due == cyc) rv[rdq[i].m] = 1'b1;
      chk("gnt0", {31'd0, bus.m0_gnt}, {31'd0, own == 0});
      chk("gnt1", {31'd0, bus.m1_gnt}, {31'd0, own == 1});
      chk("s_sel", {31'd0, bus.s_sel}, {31'd0, xm >= 0});
      chk("s_wr", {31'd0, bus.s_wr}, {31'd0, xm >= 0 && wr[xm]});
      chk("s_addr", {16'd0, bus.s_addr}, xm < 0 ? 32'd0 : {16'd0, addr[xm]});
      chk("s_din", bus.s_din, xm < 0 ? 32'd0 : din[xm]);
      chk("rvalid0", {31'd0, bus.m0_rvalid}, {31'd0, rv[0]});
      chk("rvalid1", {31'd0, bus.m1_rvalid}, {31'd0, rv[1]});
      chk("dout0", bus.m0_dout, dout_v);
      chk("dout1", bus.m1_dout, dout_v);
      chk("irq0", {31'd0, bus.m0_irq}, {31'd0, intr_v && irq_o == 0});
      chk("irq1", {31'd0, bus.m1_irq}, {31'd0, intr_v && irq_o == 1});

      // Advance the model across the coming edge.
      while (rdq.size() > 0 && rdq[0].due <= cyc) void'(rdq.pop_front());
      if (xm >= 0) begin
        tcnt++;
        if (wr[xm]) irq_o = xm;
        else rdq.push_back('{due: cyc + RD_LAT, m: xm});
      end
      nown = own;
      if (own < 0) begin
        if (pend[0] && pend[1]) nown = 1 - last_g;
        else if (pend[0]) nown = 0;
        else if (pend[1]) nown = 1;
      end else begin
        o = 1 - own;
        if (!pend[own]) nown = pend[o] ? o : -1;
        else if (pend[o] && tcnt >= MAX_BURST) nown = o;
      end
      if (nown != own) begin
        if (nown >= 0) last_g = nown;
        tcnt = 0;
        own = nown;
      end
      if (xm >= 0) pend[xm] = 1'b0;
      cyc++;
    end
  endtask

  initial begin
    cyc = 0;
    for (int m = 0; m < 2; m++) begin
      wr[m] = 1'b0; addr[m] = 16'd0; din[m] = 32'd0;
    end
    dout_v = 32'd0;
    intr_v = 1'b1;
    model_reset();
    drive();
    #3 chk_quiet("reset");
    @(posedge clk); @(posedge clk); #2;
    reset_n = 1'b1;

    run_cycles(300, 30, 30);
    do_reset();
    run_cycles(400, 95, 60);
    do_reset();
    run_cycles(400, 100, 100);
    do_reset();
    run_cycles(300, 50, 95);
    do_reset();
    run_cycles(300, 70, 70);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
